timer_device: RTL and testbench

- Memory-mapped down-counter peripheral on the CPU data-memory port, downstream of the pipeline's M stage.
- Consumes the datapath's memory-stage outputs: address, write enable, byte enables and store data.
- Returns combinational read data that the M/W register captures in the same cycle.
- Raises an interrupt line toward the CPU exception logic on count expiry.

---
 rtl/timer_device.sv | 192 +++++++++++++++++++
 tb/tb_timer_device.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_device.sv
`timescale 1ns/1ps
// timer_device
// Memory-mapped down-counter peripheral on the CPU data-memory port.
// Optional feature macro: TIMER_PRESCALE_EN (adds the PRESCALE register at offset 3).
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous active-high reset
//   Sel     in   device selected (external address decode)
//   Adr     in   byte address, only Adr[3:2] decoded
//   WE      in   store strobe (qualified by Sel)
//   ByteEN  in   byte-lane enables for the store
//   DataW   in   lane-aligned store data
//   DataR   out  combinational read data (0 when Sel=0)
//   IRQ     out  interrupt request = IM & irq flag
//
// Register map (Adr[3:2]): 0 CTRL {IM, Mode[1:0], En}, 1 PRESET, 2 COUNT (RO),
// 3 PRESCALE when TIMER_PRESCALE_EN, otherwise reserved (reads 0).
module timer_device #(
    parameter int CNT_W      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Sel,
    input  logic [31:0] Adr,
    input  logic        WE,
    input  logic [3:0]  ByteEN,
    input  logic [31:0] DataW,
    output logic [31:0] DataR,
    output logic        IRQ
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_q, irq_d;

    logic [31:0]      lane_mask;
    logic             en, wr, wr_ctrl, wr_preset, wr_presc, wr_clears_irq;
    logic [1:0]       mode;
    logic             tick;

    // Expand byte enables to a bit mask for read-modify-write merges.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{ByteEN[gi]}};
        end
    endgenerate

    assign en        = ctrl_q[0];
    assign mode      = ctrl_q[2:1];
    assign wr        = Sel & WE;
    assign wr_ctrl   = wr && (Adr[3:2] == 2'd0);
    assign wr_preset = wr && (Adr[3:2] == 2'd1);
    assign wr_presc  = wr && (Adr[3:2] == 2'd3);

    // A store to CTRL or PRESET acknowledges a latched interrupt.
    assign wr_clears_irq = wr_ctrl | wr_preset;

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] pc_q, pc_d;
    logic [31:0]           presc_merge;

    // The count advances only when the prescale counter reaches PRESCALE.
    assign tick = (pc_q == presc_q);
    assign presc_merge = ({{(32-PRESCALE_W){1'b0}}, presc_q} & ~lane_mask)
                       | (DataW & lane_mask);
`else
    assign tick = 1'b1;
`endif

    logic unused_ok;
    assign unused_ok = ^{Adr[31:4], Adr[1:0], wr_presc, DataW};

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;
`ifdef TIMER_PRESCALE_EN
        presc_d  = presc_q;
        pc_d     = pc_q;
`endif

        case (state_q)
            IDLE: begin
                if (en) state_d = LOAD;
            end
            LOAD: begin
                count_d = preset_q;
                // Ends the one-cycle pulse when arriving here from INT in mode 1.
                irq_d   = 1'b0;
                state_d = CNT;
`ifdef TIMER_PRESCALE_EN
                pc_d    = '0;
`endif
            end
            CNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (tick) begin
`ifdef TIMER_PRESCALE_EN
                    pc_d = '0;
`endif
                    if (count_q > CNT_ONE) begin
                        count_d = count_q - CNT_ONE;
                    end else begin
                        count_d = '0;
                        state_d = INT;
                    end
                end else begin
`ifdef TIMER_PRESCALE_EN
                    pc_d = pc_q + 1'b1;
`endif
                end
            end
            INT: begin
                irq_d = 1'b1;
                if (mode == 2'd1) begin
                    state_d = LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // CPU acknowledge; an expiry on the same edge keeps the flag set.
        if (wr_clears_irq && (state_q != INT)) irq_d = 1'b0;

        // CPU store applied last so it wins over the FSM's En clear.
        if (wr_ctrl && ByteEN[0]) ctrl_d = DataW[3:0];
        if (wr_preset)
            preset_d = (preset_q & ~lane_mask[CNT_W-1:0])
                     | (DataW[CNT_W-1:0] & lane_mask[CNT_W-1:0]);
`ifdef TIMER_PRESCALE_EN
        if (wr_presc) presc_d = presc_merge[PRESCALE_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            presc_q  <= '0;
            pc_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
`ifdef TIMER_PRESCALE_EN
            presc_q  <= presc_d;
            pc_q     <= pc_d;
`endif
        end
    end

    always_comb begin
        DataR = '0;
        if (Sel) begin
            case (Adr[3:2])
                2'd0: DataR[3:0]       = ctrl_q;
                2'd1: DataR[CNT_W-1:0] = preset_q;
                2'd2: DataR[CNT_W-1:0] = count_q;
                default: begin
`ifdef TIMER_PRESCALE_EN
                    DataR[PRESCALE_W-1:0] = presc_q;
`endif
                end
            endcase
        end
    end

    assign IRQ = ctrl_q[3] & irq_q;

endmodule

// File: tb/tb_timer_device.sv
`timescale 1ns/1ps
module tb_timer_device;

    logic        clk = 1'b0;
    logic        reset;
    logic        Sel;
    logic [31:0] Adr;
    logic        WE;
    logic [3:0]  ByteEN;
    logic [31:0] DataW;
    logic [31:0] DataR;
    logic        IRQ;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_PRESET = 32'h4;
    localparam logic [31:0] A_COUNT  = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

    timer_device dut (
        .clk(clk), .reset(reset), .Sel(Sel), .Adr(Adr), .WE(WE),
        .ByteEN(ByteEN), .DataW(DataW), .DataR(DataR), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    // Store lands on the next rising edge; returns 1 time unit after it.
    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        Sel = 1'b1; WE = 1'b1; Adr = a; ByteEN = be; DataW = d;
        @(posedge clk); #1;
        Sel = 1'b0; WE = 1'b0; ByteEN = 4'h0; DataW = '0;
        $display("[TB] write adr=%h be=%b data=%h", a, be, d);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Sel = 1'b1; WE = 1'b0; Adr = a;
        #1;
        d = DataR;
        Sel = 1'b0;
        $display("[TB] read  adr=%h data=%h", a, d);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b1; Sel = 1'b0; WE = 1'b0; Adr = '0; ByteEN = '0; DataW = '0;
        #2;
        tests++; if (IRQ !== 1'b0) begin fails++; $display("FAIL rst_irq: got %b exp 0", IRQ); end
        tests++; if (DataR !== 32'h0) begin fails++; $display("FAIL rst_datar_unsel: got %h exp 0", DataR); end
        step(2);
        reset = 1'b0;
        step(1);
        // Reset asserted in the middle of a count.
        wr(A_PRESET, 4'hF, 32'd100);
        wr(A_CTRL, 4'hF, 32'h1);
        step(10);
        rd(A_COUNT, d);
        tests++; if (d !== 32'd92) begin fails++; $display("FAIL rst_precount: got %0d exp 92", d); end
        reset = 1'b1;
        #1;
        rd(A_COUNT, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_count: got %h exp 0", d); end
        rd(A_CTRL, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_ctrl: got %h exp 0", d); end
        rd(A_PRESET, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_preset: got %h exp 0", d); end
        tests++; if (IRQ !== 1'b0) begin fails++; $display("FAIL rst_irq_mid: got %b exp 0", IRQ); end
        step(1);
        reset = 1'b0;
        step(3);
        rd(A_COUNT, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_idle_count: got %h exp 0", d); end
    endtask

    task automatic test_mode0;
        logic [31:0] d;
        wr(A_PRESET, 4'hF, 32'd5);
        wr(A_CTRL, 4'hF, 32'h9);      // edge 0
        step(2);                       // after edge 2
        rd(A_COUNT, d);
        tests++; if (d !== 32'd5) begin fails++; $display("FAIL m0_count_e2: got %0d exp 5", d); end
        step(4);                       // after edge 6
        rd(A_COUNT, d);
        tests++; if (d !== 32'd1) begin fails++; $display("FAIL m0_count_e6: got %0d exp 1", d); end
        step(1);                       // after edge 7
        rd(A_COUNT, d);
        tests++; if (d !== 32'd0) begin fails++; $display("FAIL m0_count_e7: got %0d exp 0", d); end
        tests++; if (IRQ !== 1'b0) begin fails++; $display("FAIL m0_irq_e7: got %b exp 0", IRQ); end
        step(1);                       // after edge 8
        tests++; if (IRQ !== 1'b1) begin fails++; $display("FAIL m0_irq_e8: got %b exp 1", IRQ); end
        rd(A_CTRL, d);
        tests++; if (d !== 32'h8) begin fails++; $display("FAIL m0_ctrl_e8: got %h exp 8", d); end
        step(3);
        tests++; if (IRQ !== 1'b1) begin fails++; $display("FAIL m0_irq_held: got %b exp 1", IRQ); end
        wr(A_CTRL, 4'hF, 32'h8);
        tests++; if (IRQ !== 1'b0) begin fails++; $display("FAIL m0_irq_ack: got %b exp 0", IRQ); end
    endtask

    task automatic test_mode1;
        logic [31:0] d;
        logic [31:0] exp_cnt;
        logic        exp_irq;
        int          ph;
        wr(A_PRESET, 4'hF, 32'd2);
        wr(A_CTRL, 4'hF, 32'hB);      // edge 0
        for (int e = 1; e <= 22; e++) begin
            step(1);
            rd(A_COUNT, d);
            if (e < 2) exp_cnt = 32'd0;
            else begin
                ph = (e - 2) % 4;
                exp_cnt = (ph == 0) ? 32'd2 : (ph == 1) ? 32'd1 : 32'd0;
            end
            exp_irq = (e >= 5) && (((e - 5) % 4) == 0);
            tests++; if (d !== exp_cnt) begin fails++; $display("FAIL m1_count e=%0d: got %0d exp %0d", e, d, exp_cnt); end
            tests++; if (IRQ !== exp_irq) begin fails++; $display("FAIL m1_irq e=%0d: got %b exp %b", e, IRQ, exp_irq); end
        end
        wr(A_CTRL, 4'hF, 32'h0);      // edge 23: count 2 -> 1, then idle
        step(2);
    endtask

    task automatic test_byte_lanes;
        logic [31:0] d;
        wr(A_PRESET, 4'hF, 32'h11223344);
        wr(A_PRESET, 4'b0101, 32'hAABBCCDD);
        rd(A_PRESET, d);
        tests++; if (d !== 32'h11BB33DD) begin fails++; $display("FAIL bl_preset_0101: got %h exp 11BB33DD", d); end
        wr(A_PRESET, 4'b1000, 32'h55667788);
        rd(A_PRESET, d);
        tests++; if (d !== 32'h55BB33DD) begin fails++; $display("FAIL bl_preset_1000: got %h exp 55BB33DD", d); end
        wr(A_COUNT, 4'hF, 32'hFFFFFFFF);
        rd(A_COUNT, d);
        tests++; if (d !== 32'd1) begin fails++; $display("FAIL bl_count_ro: got %h exp 1", d); end
        wr(A_CTRL, 4'hF, 32'hFFFFFFF0);
        rd(A_CTRL, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL bl_ctrl_upper: got %h exp 0", d); end
`ifndef TIMER_PRESCALE_EN
        wr(A_RSVD, 4'hF, 32'h12345678);
        rd(A_RSVD, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL bl_rsvd: got %h exp 0", d); end
`endif
    endtask

    task automatic test_disable;
        logic [31:0] d;
        wr(A_PRESET, 4'hF, 32'd10);
        wr(A_CTRL, 4'hF, 32'h9);      // edge 0
        step(5);                       // after edge 5: 10,9,8,7
        rd(A_COUNT, d);
        tests++; if (d !== 32'd7) begin fails++; $display("FAIL dis_count_e5: got %0d exp 7", d); end
        wr(A_CTRL, 4'hF, 32'h8);      // edge 6: last decrement to 6
        step(4);
        rd(A_COUNT, d);
        tests++; if (d !== 32'd6) begin fails++; $display("FAIL dis_frozen: got %0d exp 6", d); end
        tests++; if (IRQ !== 1'b0) begin fails++; $display("FAIL dis_irq: got %b exp 0", IRQ); end
        wr(A_CTRL, 4'hF, 32'h9);      // edge E
        step(2);
        rd(A_COUNT, d);
        tests++; if (d !== 32'd10) begin fails++; $display("FAIL dis_reload: got %0d exp 10", d); end
        step(10);                      // after E+12
        rd(A_COUNT, d);
        tests++; if (d !== 32'd0) begin fails++; $display("FAIL dis_count_zero: got %0d exp 0", d); end
        tests++; if (IRQ !== 1'b0) begin fails++; $display("FAIL dis_irq_early: got %b exp 0", IRQ); end
        step(1);                       // after E+13
        tests++; if (IRQ !== 1'b1) begin fails++; $display("FAIL dis_irq_fire: got %b exp 1", IRQ); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        wr(A_PRESET, 4'hF, 32'd1);
        tests++; if (IRQ !== 1'b0) begin fails++; $display("FAIL b2b_ack_preset: got %b exp 0", IRQ); end
        wr(A_CTRL, 4'hF, 32'h9);      // edge 0; INT at edge 4
        step(3);
        wr(A_CTRL, 4'hF, 32'h9);      // edge 4: CPU write keeps En
        rd(A_CTRL, d);
        tests++; if (d !== 32'h9) begin fails++; $display("FAIL b2b_ctrl_en: got %h exp 9", d); end
        wr(A_CTRL, 4'hF, 32'h0);
        step(2);
        // PRESET store while counting must not touch COUNT.
        wr(A_PRESET, 4'hF, 32'd8);
        wr(A_CTRL, 4'hF, 32'h1);      // edge 0
        step(2);                       // count 8
        wr(A_PRESET, 4'hF, 32'd3);    // edge 3: count 7
        step(1);                       // edge 4: count 6
        rd(A_COUNT, d);
        tests++; if (d !== 32'd6) begin fails++; $display("FAIL b2b_count_keep: got %0d exp 6", d); end
        rd(A_PRESET, d);
        tests++; if (d !== 32'd3) begin fails++; $display("FAIL b2b_preset_new: got %0d exp 3", d); end
        wr(A_CTRL, 4'hF, 32'h0);
        step(2);
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale;
        logic [31:0] d;
        wr(A_RSVD, 4'hF, 32'd3);
        wr(A_PRESET, 4'hF, 32'd2);
        wr(A_CTRL, 4'hF, 32'h9);      // edge 0; LOAD at edge 2
        step(5);
        rd(A_COUNT, d);
        tests++; if (d !== 32'd2) begin fails++; $display("FAIL ps_count_e5: got %0d exp 2", d); end
        step(1);
        rd(A_COUNT, d);
        tests++; if (d !== 32'd1) begin fails++; $display("FAIL ps_count_e6: got %0d exp 1", d); end
        step(4);
        tests++; if (IRQ !== 1'b0) begin fails++; $display("FAIL ps_irq_e10: got %b exp 0", IRQ); end
        step(1);
        tests++; if (IRQ !== 1'b1) begin fails++; $display("FAIL ps_irq_e11: got %b exp 1", IRQ); end
    endtask
`endif

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_byte_lanes();
        test_disable();
        test_back_to_back();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
